// File: rtl/id_exe_stage_pkg.sv
// Shared definitions for the ID->EXE pipeline register: write-back address
// encodings, field widths, the registered EXE bundle and its NOP value.
package id_exe_stage_pkg;

    localparam int EXE_SRC_W     = 2;
    localparam int ALU_OPER_W    = 4;
    localparam int WB_ADDR_SRC_W = 2;
    localparam int REG_ADDR_W    = 5;

    // Destination-register source selected by the decoder
    typedef enum logic [WB_ADDR_SRC_W-1:0] {
        WB_ADDR_RD   = 2'd0,
        WB_ADDR_RT   = 2'd1,
        WB_ADDR_LINK = 2'd2,
        WB_ADDR_RSVD = 2'd3
    } wb_addr_src_e;

    localparam logic [REG_ADDR_W-1:0] REG_LINK = 5'd31;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Everything the EXE stage holds for one instruction
    typedef struct packed {
        logic                   valid;
        logic [31:0]            inst;
        logic [31:0]            pc_next;
        logic [31:0]            data_rs;
        logic [31:0]            data_rt;
        logic [31:0]            imm;
        logic [EXE_SRC_W-1:0]   a_src;
        logic [EXE_SRC_W-1:0]   b_src;
        logic [ALU_OPER_W-1:0]  alu_oper;
        logic                   mem_ren;
        logic                   mem_wen;
        logic                   wb_data_src;
        logic                   sign;
        logic                   fwd_m;
        logic [REG_ADDR_W-1:0]  regw_addr;
        logic                   wb_wen;
        logic                   is_load;
    } exe_bundle_t;

    // A bubble: no valid instruction, destination $zero, no write-back
    localparam exe_bundle_t EXE_NOP = '0;

    // Resolve the destination register from the instruction word; the
    // reserved code yields $zero so the write-back gets suppressed downstream
    function automatic logic [REG_ADDR_W-1:0] resolve_regw_addr(
        input logic [WB_ADDR_SRC_W-1:0] src,
        input logic [31:0]              inst
    );
        logic [REG_ADDR_W-1:0] addr;
        case (wb_addr_src_e'(src))
            WB_ADDR_RD:   addr = inst[15:11];
            WB_ADDR_RT:   addr = inst[20:16];
            WB_ADDR_LINK: addr = REG_LINK;
            default:      addr = REG_ZERO;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/id_exe_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, then increment only below saturation
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_exe_stage.sv
// ID->EXE pipeline register. Latches the decode bundle under control of the
// pipeline controller, resolves the destination register at latch time and
// feeds hazard information back. Also counts real instructions and bubbles.
module id_exe_stage
    import id_exe_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     exe_en,
    input  logic                     exe_rst,
    input  logic                     id_valid,
    input  logic [31:0]              inst_id,
    input  logic [31:0]              pc_next_id,
    input  logic [31:0]              data_rs_id,
    input  logic [31:0]              data_rt_id,
    input  logic [31:0]              imm_id,
    input  logic [EXE_SRC_W-1:0]     exe_a_src_id,
    input  logic [EXE_SRC_W-1:0]     exe_b_src_id,
    input  logic [ALU_OPER_W-1:0]    exe_alu_oper_id,
    input  logic                     mem_ren_id,
    input  logic                     mem_wen_id,
    input  logic [WB_ADDR_SRC_W-1:0] wb_addr_src_id,
    input  logic                     wb_data_src_id,
    input  logic                     wb_wen_id,
    input  logic                     is_load_id,
    input  logic                     sign_id,
    input  logic                     fwd_m_id,
    input  logic                     cnt_clr,
    output logic                     exe_valid,
    output logic [31:0]              inst_exe,
    output logic [31:0]              pc_next_exe,
    output logic [31:0]              data_rs_exe,
    output logic [31:0]              data_rt_exe,
    output logic [31:0]              imm_exe,
    output logic [EXE_SRC_W-1:0]     exe_a_src_exe,
    output logic [EXE_SRC_W-1:0]     exe_b_src_exe,
    output logic [ALU_OPER_W-1:0]    exe_alu_oper_exe,
    output logic                     mem_ren_exe,
    output logic                     mem_wen_exe,
    output logic                     wb_data_src_exe,
    output logic                     sign_exe,
    output logic                     fwd_m_exe,
    output logic [REG_ADDR_W-1:0]    regw_addr_exe,
    output logic                     wb_wen_exe,
    output logic                     is_load_exe,
    output logic [CNT_W-1:0]         inst_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    exe_bundle_t           bundle_q;
    exe_bundle_t           bundle_d;
    logic [REG_ADDR_W-1:0] regw_addr_d;
    logic                  latch_evt;
    logic                  bubble_evt;

    // Next EXE contents: flush beats enable, enable with no instruction is a
    // bubble, otherwise hold; write-back to $zero is never advertised
    always_comb begin
        bundle_d    = bundle_q;
        regw_addr_d = resolve_regw_addr(wb_addr_src_id, inst_id);
        latch_evt   = 1'b0;
        bubble_evt  = 1'b0;
        if (exe_rst) begin
            bundle_d   = EXE_NOP;
            bubble_evt = 1'b1;
        end else if (exe_en) begin
            if (id_valid) begin
                bundle_d.valid       = 1'b1;
                bundle_d.inst        = inst_id;
                bundle_d.pc_next     = pc_next_id;
                bundle_d.data_rs     = data_rs_id;
                bundle_d.data_rt     = data_rt_id;
                bundle_d.imm         = imm_id;
                bundle_d.a_src       = exe_a_src_id;
                bundle_d.b_src       = exe_b_src_id;
                bundle_d.alu_oper    = exe_alu_oper_id;
                bundle_d.mem_ren     = mem_ren_id;
                bundle_d.mem_wen     = mem_wen_id;
                bundle_d.wb_data_src = wb_data_src_id;
                bundle_d.sign        = sign_id;
                bundle_d.fwd_m       = fwd_m_id;
                bundle_d.regw_addr   = regw_addr_d;
                bundle_d.wb_wen      = wb_wen_id && (regw_addr_d != REG_ZERO);
                bundle_d.is_load     = is_load_id && mem_ren_id;
                latch_evt            = 1'b1;
            end else begin
                bundle_d   = EXE_NOP;
                bubble_evt = 1'b1;
            end
        end
    end

    // Pipeline register; reset drops straight to the NOP bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= EXE_NOP;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign exe_valid        = bundle_q.valid;
    assign inst_exe         = bundle_q.inst;
    assign pc_next_exe      = bundle_q.pc_next;
    assign data_rs_exe      = bundle_q.data_rs;
    assign data_rt_exe      = bundle_q.data_rt;
    assign imm_exe          = bundle_q.imm;
    assign exe_a_src_exe    = bundle_q.a_src;
    assign exe_b_src_exe    = bundle_q.b_src;
    assign exe_alu_oper_exe = bundle_q.alu_oper;
    assign mem_ren_exe      = bundle_q.mem_ren;
    assign mem_wen_exe      = bundle_q.mem_wen;
    assign wb_data_src_exe  = bundle_q.wb_data_src;
    assign sign_exe         = bundle_q.sign;
    assign fwd_m_exe        = bundle_q.fwd_m;
    assign regw_addr_exe    = bundle_q.regw_addr;
    assign wb_wen_exe       = bundle_q.wb_wen;
    assign is_load_exe      = bundle_q.is_load;

    sat_counter #(.CNT_W(CNT_W)) u_inst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (latch_evt),
        .clr   (cnt_clr),
        .cnt   (inst_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_evt),
        .clr   (cnt_clr),
        .cnt   (bubble_cnt)
    );

endmodule
